// File: rtl/fp32_div_seq.sv
// Sequential IEEE-754 single-precision divider: result = a_operand / b_operand.
// Restoring division over 24-bit significands, UNROLL quotient bits per clock.
// Denormal operands are flushed to zero. Rounding is round-up only when guard
// and sticky are both set, so exact halfway cases truncate.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready is high only in IDLE)
//   a_operand, b_operand  dividend, divisor (FP32)
//   out_valid / out_ready result handshake
//   result                FP32 quotient
//   exception             an operand exponent is 8'hFF (result 0)
//   div_by_zero           divisor zero or denormal
//   overflow, underflow   result exponent out of range
module fp32_div_seq #(
    parameter int unsigned UNROLL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        exception,
    output logic        div_by_zero,
    output logic        overflow,
    output logic        underflow
);

    localparam int unsigned QW    = 26;         // quotient bits
    localparam int unsigned SW    = 24;         // significand width incl. hidden bit
    localparam int unsigned RW    = SW + 1;     // remainder width (holds 2*rem)
    localparam int unsigned STEPS = QW / UNROLL;
    localparam int unsigned CW    = 5;

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t          state_q, state_d;
    logic            sign_q, sign_d;
    logic [7:0]      ea_q, ea_d;
    logic [7:0]      eb_q, eb_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [SW-1:0]   dvs_q, dvs_d;
    logic [QW-1:0]   quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     result_q, result_d;
    logic            exc_q, exc_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            out_valid_q, out_valid_d;

    // Divider step results
    logic [RW-1:0]   rem_t;
    logic [QW-1:0]   quo_t;

    // Normalisation / rounding results
    logic            norm;
    logic [22:0]     mant_raw;
    logic            guard;
    logic            sticky;
    logic [23:0]     mant_sum;
    logic            carry;
    logic signed [9:0] exp_n;

    logic [7:0]      a_exp, b_exp;
    logic            op_sign;

    assign a_exp   = a_operand[30:23];
    assign b_exp   = b_operand[30:23];
    assign op_sign = a_operand[31] ^ b_operand[31];

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign exception   = exc_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

    // UNROLL restoring-division steps per clock, quotient shifted in MSB first
    always_comb begin
        rem_t = rem_q;
        quo_t = quo_q;
        for (int i = 0; i < int'(UNROLL); i++) begin
            if (rem_t >= {1'b0, dvs_q}) begin
                rem_t = rem_t - {1'b0, dvs_q};
                quo_t = {quo_t[QW-2:0], 1'b1};
            end else begin
                quo_t = {quo_t[QW-2:0], 1'b0};
            end
            rem_t = {rem_t[RW-2:0], 1'b0};
        end
    end

    // Quotient lies in [0.5, 2): pick the 23 fraction bits, guard and sticky
    always_comb begin
        norm     = quo_q[QW-1];
        mant_raw = norm ? quo_q[24:2] : quo_q[23:1];
        guard    = norm ? quo_q[1] : quo_q[0];
        sticky   = (norm & quo_q[0]) | (rem_q != '0);
        mant_sum = {1'b0, mant_raw} + 24'(guard & sticky);
        carry    = mant_sum[23];
        exp_n    = 10'({2'b00, ea_q}) - 10'({2'b00, eb_q}) + 10'd127
                 - 10'(!norm) + 10'(carry);
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        ea_d        = ea_q;
        eb_d        = eb_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        exc_d       = exc_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = op_sign;
                    ea_d   = a_exp;
                    eb_d   = b_exp;
                    if ((a_exp == 8'hFF) || (b_exp == 8'hFF) || (b_exp == 8'h00)
                        || (a_exp == 8'h00)) begin
                        // Special operands finish at the accept edge
                        exc_d       = (a_exp == 8'hFF) || (b_exp == 8'hFF);
                        dbz_d       = !exc_d && (b_exp == 8'h00);
                        ovf_d       = 1'b0;
                        unf_d       = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                        if (exc_d) begin
                            result_d = 32'h0;
                        end else if (dbz_d) begin
                            result_d = {op_sign, 8'hFF, 23'h0};
                        end else begin
                            result_d = {op_sign, 31'h0};
                        end
                    end else begin
                        rem_d   = {2'b01, a_operand[22:0]};
                        dvs_d   = {1'b1, b_operand[22:0]};
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                rem_d = rem_t;
                quo_d = quo_t;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(STEPS - 1)) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                exc_d       = 1'b0;
                dbz_d       = 1'b0;
                ovf_d       = 1'b0;
                unf_d       = 1'b0;
                out_valid_d = 1'b1;
                state_d     = DONE;
                if (exp_n >= 10'sd255) begin
                    ovf_d    = 1'b1;
                    result_d = {sign_q, 8'hFF, 23'h0};
                end else if (exp_n <= 10'sd0) begin
                    unf_d    = 1'b1;
                    result_d = {sign_q, 31'h0};
                end else begin
                    result_d = {sign_q, exp_n[7:0], mant_sum[22:0]};
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            ea_q        <= '0;
            eb_q        <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            exc_q       <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            ea_q        <= ea_d;
            eb_q        <= eb_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            exc_q       <= exc_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fp32_div_seq.sv
// Bench for fp32_div_seq: one instance per legal UNROLL value, shared operand
// bus, scoreboard of expected result/flags/latency. Latency is the number of
// clock edges after the accept edge until out_valid is seen; special operands
// complete on the accept edge itself, so their out_valid is high in the very
// next cycle (0 further edges).
module tb_fp32_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  in_valid;
    logic [31:0] a_operand, b_operand;
    logic        out_ready;
    logic [1:0]  in_ready, out_valid, exception, div_by_zero, overflow, underflow;
    logic [31:0] result [2];

    always #5 clk = ~clk;

    fp32_div_seq #(.UNROLL(1)) u_dut_u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a_operand(a_operand), .b_operand(b_operand), .out_valid(out_valid[0]),
        .out_ready(out_ready), .result(result[0]), .exception(exception[0]),
        .div_by_zero(div_by_zero[0]), .overflow(overflow[0]), .underflow(underflow[0])
    );

    fp32_div_seq #(.UNROLL(2)) u_dut_u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a_operand(a_operand), .b_operand(b_operand), .out_valid(out_valid[1]),
        .out_ready(out_ready), .result(result[1]), .exception(exception[1]),
        .div_by_zero(div_by_zero[1]), .overflow(overflow[1]), .underflow(underflow[1])
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;   // {exception, div_by_zero, overflow, underflow}
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags_of(input int s);
        return {exception[s], div_by_zero[s], overflow[s], underflow[s]};
    endfunction

    // Reference: wide integer division of significands, then round/normalise
    function automatic void ref_div(input logic [31:0] av, input logic [31:0] bv,
                                    output logic [31:0] r, output logic [3:0] f,
                                    output bit spec);
        logic s;
        int ea, eb, e, sh;
        longint unsigned num, den, q, rm, m, low;
        bit g, st;
        s = av[31] ^ bv[31];
        ea = int'(av[30:23]);
        eb = int'(bv[30:23]);
        f = 4'b0000;
        r = 32'h0;
        spec = 1'b1;
        if (ea == 255 || eb == 255) begin
            f = 4'b1000;
        end else if (eb == 0) begin
            f = 4'b0100;
            r = {s, 8'hFF, 23'h0};
        end else if (ea == 0) begin
            r = {s, 31'h0};
        end else begin
            spec = 1'b0;
            num = 64'({1'b1, av[22:0]}) << 40;
            den = 64'({1'b1, bv[22:0]});
            q   = num / den;
            rm  = num % den;
            if (q >= (64'd1 << 40)) begin sh = 17; e = ea - eb + 127; end
            else begin sh = 16; e = ea - eb + 126; end
            m   = q >> sh;
            g   = q[sh-1];
            low = q & ((64'd1 << (sh - 1)) - 64'd1);
            st  = (low != 0) || (rm != 0);
            if (g && st) m++;
            if (m == (64'd1 << 24)) begin m = 64'd1 << 23; e++; end
            if (e >= 255) begin
                f = 4'b0010;
                r = {s, 8'hFF, 23'h0};
            end else if (e <= 0) begin
                f = 4'b0001;
                r = {s, 31'h0};
            end else begin
                r = {s, 8'(e), m[22:0]};
            end
        end
    endfunction

    // Issue one operation to instance s, then check it against the scoreboard.
    // With bp set, out_ready is held low for 5 cycles after out_valid.
    task automatic do_op(input int s, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] er, input logic [3:0] ef, input int el,
                         input bit bp);
        exp_t e, got;
        int lat;
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready[s]), 64'd1);
        a_operand = av;
        b_operand = bv;
        in_valid[s] = 1'b1;
        if (bp) out_ready = 1'b0;
        @(posedge clk);
        e.res = er; e.flg = ef; e.lat = el;
        sb_q.push_back(e);
        #1;
        in_valid[s] = 1'b0;
        a_operand = $urandom;
        b_operand = $urandom;
        lat = 0;
        while (out_valid[s] !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = sb_q.pop_front();
        check("latency", 64'(lat), 64'(got.lat));
        check("result", 64'(result[s]), 64'(got.res));
        check("flags", 64'(flags_of(s)), 64'(got.flg));
        if (bp) begin
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                in_valid[s] = 1'b1;
                a_operand = $urandom;
                b_operand = $urandom;
                @(posedge clk);
                #1;
                check("bp_result", 64'(result[s]), 64'(got.res));
                check("bp_flags", 64'(flags_of(s)), 64'(got.flg));
                check("bp_out_valid", 64'(out_valid[s]), 64'd1);
                check("bp_in_ready", 64'(in_ready[s]), 64'd0);
            end
            @(negedge clk);
            in_valid[s] = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("out_valid_clear", 64'(out_valid[s]), 64'd0);
        check("in_ready_back", 64'(in_ready[s]), 64'd1);
    endtask

    task automatic rand_op(input int s, input bit wide);
        logic [31:0] av, bv, r;
        logic [3:0]  f;
        bit spec;
        av = $urandom;
        bv = $urandom;
        if (!wide) begin
            av[30:23] = 8'($urandom_range(100, 160));
            bv[30:23] = 8'($urandom_range(100, 160));
        end
        ref_div(av, bv, r, f, spec);
        do_op(s, av, bv, r, f, spec ? 0 : (26 / (s + 1) + 1), 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 2'b00;
        out_ready = 1'b1;
        a_operand = 32'h0;
        b_operand = 32'h0;
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst_in_ready", 64'(in_ready[s]), 64'd1);
            check("rst_out_valid", 64'(out_valid[s]), 64'd0);
            check("rst_result", 64'(result[s]), 64'd0);
            check("rst_flags", 64'(flags_of(s)), 64'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, UNROLL=1
        do_op(0, 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27, 1'b0);
        do_op(0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 27, 1'b0);
        do_op(0, 32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 0, 1'b0);
        do_op(0, 32'h7F800000, 32'h3F800000, 32'h00000000, 4'b1000, 0, 1'b0);
        do_op(0, 32'h7F800000, 32'h00000000, 32'h00000000, 4'b1000, 0, 1'b0);
        do_op(0, 32'h00000000, 32'h00000000, 32'h7F800000, 4'b0100, 0, 1'b0);
        do_op(0, 32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 0, 1'b0);
        do_op(0, 32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 27, 1'b0);
        do_op(0, 32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 27, 1'b0);

        // Directed vectors, UNROLL=2
        do_op(1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 14, 1'b0);
        do_op(1, 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 14, 1'b0);
        do_op(1, 32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 0, 1'b0);

        // Backpressure with ignored in_valid pulses
        do_op(0, 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27, 1'b1);
        do_op(1, 32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 14, 1'b1);

        // Random operands through the reference model
        for (int i = 0; i < 12; i++) begin
            rand_op(0, 1'b0);
            rand_op(1, 1'b0);
            rand_op(i % 2, 1'b1);
        end

        // Async reset in the middle of a division; previous op left overflow set
        do_op(0, 32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 27, 1'b0);
        @(negedge clk);
        a_operand = 32'h40C00000;
        b_operand = 32'h40000000;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid[0]), 64'd0);
        check("arst_flags", 64'(flags_of(0)), 64'd0);
        check("arst_result", 64'(result[0]), 64'd0);
        check("arst_in_ready", 64'(in_ready[0]), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp32_div_seq.md
Name: fp32_div_seq

Overview:
- Sequential IEEE-754 single-precision divider (quotient = a / b), the inverse of the team's combinational FP32 multiplier.
- Used in the SA datapath for normalisation/scaling; iterative restoring division over 24-bit significands.
- Valid/ready handshake on both sides; one operation in flight.
- Flag semantics and special-value policy match the multiplier: exception, overflow and underflow flags; exception result 0.

Parameters:
UNROLL, 1, quotient bits resolved per clock; legal values 1 or 2; DIV phase lasts 26/UNROLL cycles

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
a_operand  input  32  dividend, FP32
b_operand  input  32  divisor, FP32
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
result  output  32  FP32 quotient
exception  output  1  either operand exponent == 8'hFF
div_by_zero  output  1  divisor zero or denormal
overflow  output  1  result exponent >= 255
underflow  output  1  result exponent <= 0

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - state = IDLE; out_valid, result and all flags = 0.
  - in_ready = 1, since it is combinational (state == IDLE).
  - Reset asserted mid-operation aborts it; no result is produced.
- FSM states: IDLE, DIV, NORM, DONE.
- IDLE:
  - Accept when in_valid & in_ready.
  - Latch sign = a[31]^b[31] and both exponents.
  - Significands: {1,mant}. An exponent of 0 means the operand is flushed to zero (no denormal support).
- Special cases, resolved at the accept edge; go directly to DONE (out_valid high next cycle). Priority is as listed:
  1. Either exponent == FF: exception=1, result=32'h0.
  2. b zero: div_by_zero=1, result={sign,8'hFF,23'h0}.
  3. a zero: result={sign,31'h0}, no flags.
  4. Otherwise: go to DIV with remainder=A, divisor=B, count=0.
- DIV:
  - Restoring division produces 26 quotient bits q[25:0], MSB first, representing A/B with the binary point after q[25].
  - Per bit: if rem >= B then q bit = 1 and rem -= B; rem <<= 1.
  - UNROLL bits per edge; after 26/UNROLL edges, go to NORM.
- NORM (1 cycle): norm = q[25].
  - norm=1: mant = q[24:2], guard = q[1], sticky = q[0] | (rem != 0).
  - norm=0: mant = q[23:1], guard = q[0], sticky = (rem != 0).
  - Round up only if guard & sticky; an exact halfway case truncates (same policy as the multiplier).
  - Rounding carry out of 23 bits: mant = 0, exponent + 1.
  - Exponent is 10-bit signed: e = ea - eb + 127 - (norm ? 0 : 1) + carry.
  - e >= 255: overflow=1, result={sign,8'hFF,0}.
  - e <= 0: underflow=1, result={sign,31'h0}.
  - Else: result={sign,e[7:0],mant}.
  - Go to DONE.
- DONE:
  - out_valid=1; result and flags held stable until out_ready.
  - On out_valid & out_ready: go to IDLE, clear out_valid.
  - in_ready stays 0 until IDLE, so back-to-back issue costs one idle cycle.
- Latency from accept edge to out_valid:
  - Normal path: 26/UNROLL + 1 cycles (27 for UNROLL=1, 14 for UNROLL=2).
  - Special path: 1 cycle.
- in_valid in non-IDLE states is ignored; operands need only be stable at the accept edge.
- Flags are mutually exclusive and are valid only with out_valid.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2), UNROLL=1 -> result 0x40400000, all flags 0, out_valid exactly 27 cycles after accept.
- 0x3F800000 / 0x40400000 (1/3), norm=0 path -> result 0x3EAAAAAB (guard=1, sticky=1, rounded up); repeat with UNROLL=2 -> same result, latency 14.
- 0xBF800000 / 0x00000000 -> div_by_zero=1, result 0xFF800000, out_valid 1 cycle after accept; 0x7F800000 / 0x3F800000 -> exception=1, result 0x00000000.
- 0x7F000000 / 0x3E800000 (e=256) -> overflow=1, result 0x7F800000; 0x00800000 / 0x40000000 (e=0) -> underflow=1, result 0x00000000.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> result and flags stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
- Async reset: drop rst_n at DIV cycle 10 -> out_valid=0 and flags=0 immediately with no clock edge, in_ready=1; after release, a new 6/2 operation returns 0x40400000.
